// File: rtl/cineraria_led_defs.sv
// Shared definitions for the LED sequencer: register map, CONTROL/STATUS bit
// positions and the sequencer state encoding.
package cineraria_led_defs;

    localparam logic [2:0] ADDR_DIRECT   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PRESCALE = 3'd2;
    localparam logic [2:0] ADDR_LAST     = 3'd3;
    localparam logic [2:0] ADDR_TADDR    = 3'd4;
    localparam logic [2:0] ADDR_TDATA    = 3'd5;
    localparam logic [2:0] ADDR_STATUS   = 3'd6;
    localparam logic [2:0] ADDR_BRIGHT   = 3'd7;

    localparam int unsigned CTRL_RUN    = 0;
    localparam int unsigned CTRL_LOOP   = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    localparam int unsigned STAT_BUSY     = 0;
    localparam int unsigned STAT_DONE     = 1;
    localparam int unsigned STAT_STEP_LSB = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/cineraria_led_prescaler.sv
// Step-period down-counter: loads PRESCALE, counts down while enabled and
// flags a one-cycle tick when it reaches zero, reloading itself on the tick.
module cineraria_led_prescaler #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] prescale,
    output logic             tick_c
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= prescale;
        end else if (enable) begin
            // Reload picks up the current PRESCALE, so mid-run edits apply here
            if (cnt == '0) cnt <= prescale;
            else           cnt <= cnt - WIDTH'(1);
        end
    end

    assign tick_c = enable && !load && (cnt == '0);

endmodule

// File: rtl/cineraria_led_sequencer.sv
// Avalon-MM LED bank controller: CPU direct value or table-driven pattern
// sequencer. Optional PWM brightness gating when CINERARIA_LED_PWM_EN is defined.
module cineraria_led_sequencer
    import cineraria_led_defs::*;
#(
    parameter int unsigned LED_WIDTH      = 10,
    parameter int unsigned TABLE_AW       = 4,
    parameter int unsigned PRESCALE_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    output logic [LED_WIDTH-1:0] out_port,
    output logic                 irq
);

    localparam int unsigned DEPTH = 2 ** TABLE_AW;

    state_t                    state;
    logic [TABLE_AW-1:0]       step;
    logic [LED_WIDTH-1:0]      direct;
    logic                      loop;
    logic                      irq_en;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [TABLE_AW-1:0]       last;
    logic [TABLE_AW-1:0]       taddr;
    logic                      done;
    logic [LED_WIDTH-1:0]      tbl [DEPTH];

    logic                      wr_en;
    logic                      wr_ctrl;
    logic                      busy;
    logic                      start_c;
    logic                      abort_c;
    logic                      tick_c;
    logic                      finish_c;
    logic                      done_d;
    logic                      irq_en_d;
    logic [LED_WIDTH-1:0]      led_sel;
    logic [LED_WIDTH-1:0]      led_gated;
    logic                      unused_wd;

    assign wr_en    = chipselect && !write_n;
    assign wr_ctrl  = wr_en && (address == ADDR_CONTROL);
    assign busy     = (state == ST_RUN);
    assign start_c  = !busy && wr_ctrl && writedata[CTRL_RUN];
    assign abort_c  = busy && wr_ctrl && !writedata[CTRL_RUN];
    assign finish_c = busy && tick_c && !abort_c && !(step < last) && !loop;
    assign led_sel  = busy ? tbl[step] : direct;
    assign unused_wd = ^writedata;

    cineraria_led_prescaler #(
        .WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (start_c),
        .enable   (busy),
        .prescale (prescale),
        .tick_c   (tick_c)
    );

    // Next values of IRQ_EN and DONE so irq can be registered without lag
    always_comb begin
        irq_en_d = irq_en;
        done_d   = done;
        if (wr_ctrl)
            irq_en_d = writedata[CTRL_IRQ_EN];
        if (wr_en && (address == ADDR_STATUS) && writedata[STAT_DONE])
            done_d = 1'b0;
        if (finish_c)
            done_d = 1'b1;
    end

`ifdef CINERARIA_LED_PWM_EN
    localparam int unsigned PWM_W = 8;

    logic [PWM_W-1:0] bright;
    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bright  <= '1;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            if (wr_en && (address == ADDR_BRIGHT))
                bright <= writedata[PWM_W-1:0];
        end
    end

    assign led_gated = led_sel & {LED_WIDTH{pwm_cnt < bright}};
`else
    assign led_gated = led_sel;
`endif

    // Pattern table: deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en && (address == ADDR_TDATA))
            tbl[taddr] <= writedata[LED_WIDTH-1:0];
    end

    // Register file, sequencer FSM and LED drive
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            step     <= '0;
            direct   <= '0;
            loop     <= 1'b0;
            irq_en   <= 1'b0;
            prescale <= '0;
            last     <= '0;
            taddr    <= '0;
            done     <= 1'b0;
            irq      <= 1'b0;
            out_port <= '0;
        end else begin
            if (wr_en && (address == ADDR_DIRECT))
                direct <= writedata[LED_WIDTH-1:0];
            if (wr_en && (address == ADDR_PRESCALE))
                prescale <= writedata[PRESCALE_WIDTH-1:0];
            if (wr_en && (address == ADDR_LAST))
                last <= writedata[TABLE_AW-1:0];
            if (wr_en && (address == ADDR_TADDR))
                taddr <= writedata[TABLE_AW-1:0];
            else if (wr_en && (address == ADDR_TDATA))
                taddr <= taddr + TABLE_AW'(1);
            if (wr_ctrl)
                loop <= writedata[CTRL_LOOP];

            irq_en   <= irq_en_d;
            done     <= done_d;
            irq      <= done_d && irq_en_d;
            out_port <= led_gated;

            case (state)
                ST_IDLE: begin
                    if (start_c) begin
                        state <= ST_RUN;
                        step  <= '0;
                    end
                end
                ST_RUN: begin
                    if (abort_c) begin
                        state <= ST_IDLE;
                        step  <= '0;
                    end else if (tick_c) begin
                        if (step < last) begin
                            step <= step + TABLE_AW'(1);
                        end else if (loop) begin
                            step <= '0;
                        end else begin
                            state <= ST_IDLE;
                            step  <= '0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Zero-wait-state read mux
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DIRECT:   readdata = 32'(direct);
            ADDR_CONTROL:  readdata = 32'({irq_en, loop, busy});
            ADDR_PRESCALE: readdata = 32'(prescale);
            ADDR_LAST:     readdata = 32'(last);
            ADDR_TADDR:    readdata = 32'(taddr);
            ADDR_TDATA:    readdata = 32'(tbl[taddr]);
            ADDR_STATUS: begin
                readdata[STAT_BUSY]                = busy;
                readdata[STAT_DONE]                = done;
                readdata[STAT_STEP_LSB +: TABLE_AW] = step;
            end
`ifdef CINERARIA_LED_PWM_EN
            ADDR_BRIGHT:   readdata = 32'(bright);
`else
            ADDR_BRIGHT:   readdata = '0;
`endif
            default:       readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cineraria_led_sequencer.sv
// Directed self-checking bench for cineraria_led_sequencer: direct drive,
// one-shot and loop sequencing, abort, reset mid-run, table wrap, address 7.
module tb_cineraria_led_sequencer;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  out_port;
    logic        irq;

    int n_checks;
    int n_fail;

    cineraria_led_sequencer #(
        .LED_WIDTH      (10),
        .TABLE_AW       (4),
        .PRESCALE_WIDTH (24)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; the write is captured at the next posedge
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    logic [31:0] rd;
    logic [9:0]  pat [3];

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        pat[0] = 10'h001;
        pat[1] = 10'h002;
        pat[2] = 10'h004;

        repeat (2) @(negedge clk);
        check_eq("reset_out_port", 32'(out_port), 32'h0);
        check_eq("reset_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        bus_read(3'd6, rd);
        check_eq("reset_status", rd, 32'h0);

        // Direct drive
        bus_write(3'd0, 32'h2A5);
        @(negedge clk);
        check_eq("direct_out_port", 32'(out_port), 32'h2A5);
        bus_read(3'd0, rd);
        check_eq("direct_readback", rd, 32'h2A5);
        check_eq("direct_irq", 32'(irq), 32'h0);

        // One-shot, 4 clocks per step, IRQ enabled
        bus_write(3'd4, 32'd0);
        bus_write(3'd5, 32'h001);
        bus_write(3'd5, 32'h002);
        bus_write(3'd5, 32'h004);
        bus_read(3'd4, rd);
        check_eq("taddr_autoinc", rd, 32'd3);
        bus_write(3'd3, 32'd2);
        bus_write(3'd2, 32'd3);
        bus_write(3'd1, 32'h5);
        bus_read(3'd6, rd);
        check_eq("oneshot_status_busy", rd, 32'h1);
        check_eq("oneshot_not_yet_shown", 32'(out_port), 32'h2A5);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_eq($sformatf("oneshot_step_%0d", i), 32'(out_port), 32'(pat[i / 4]));
        end
        check_eq("oneshot_irq", 32'(irq), 32'h1);
        bus_read(3'd6, rd);
        check_eq("oneshot_status_done", rd, 32'h2);
        @(negedge clk);
        check_eq("oneshot_back_to_direct", 32'(out_port), 32'h2A5);
        bus_write(3'd6, 32'h2);
        check_eq("done_clear_irq", 32'(irq), 32'h0);
        bus_read(3'd6, rd);
        check_eq("done_clear_status", rd, 32'h0);

        // Loop mode every clock, then abort
        bus_write(3'd2, 32'd0);
        bus_write(3'd1, 32'h3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq($sformatf("loop_step_%0d", i), 32'(out_port), 32'(pat[i % 3]));
        end
        bus_write(3'd1, 32'h0);
        bus_read(3'd6, rd);
        check_eq("abort_status", rd, 32'h0);
        @(negedge clk);
        check_eq("abort_direct", 32'(out_port), 32'h2A5);
        check_eq("abort_irq", 32'(irq), 32'h0);

        // Reset mid-run at step 1
        bus_write(3'd2, 32'd3);
        bus_write(3'd1, 32'h1);
        repeat (5) @(negedge clk);
        check_eq("midrun_out_port", 32'(out_port), 32'h002);
        bus_read(3'd6, rd);
        check_eq("midrun_status", rd, 32'h101);
        reset_n = 1'b0;
        #1;
        check_eq("async_reset_out_port", 32'(out_port), 32'h0);
        bus_read(3'd6, rd);
        check_eq("async_reset_status", rd, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus_write(3'd4, 32'(i));
            bus_read(3'd5, rd);
            check_eq($sformatf("table_kept_%0d", i), rd, 32'(pat[i]));
        end

        // TADDR wrap on TDATA auto-increment
        bus_write(3'd4, 32'd15);
        bus_write(3'd5, 32'h155);
        bus_write(3'd5, 32'h0AA);
        bus_read(3'd4, rd);
        check_eq("wrap_taddr", rd, 32'd1);
        bus_write(3'd4, 32'd15);
        bus_read(3'd5, rd);
        check_eq("wrap_entry15", rd, 32'h155);
        bus_write(3'd4, 32'd0);
        bus_read(3'd5, rd);
        check_eq("wrap_entry0", rd, 32'h0AA);

        // LAST=0, PRESCALE=0 one-shot finishes after a single period
        bus_write(3'd1, 32'h5);
        @(negedge clk);
        check_eq("last0_out_port", 32'(out_port), 32'h0AA);
        check_eq("last0_irq", 32'(irq), 32'h1);
        bus_read(3'd6, rd);
        check_eq("last0_status", rd, 32'h2);
        @(negedge clk);
        check_eq("last0_direct", 32'(out_port), 32'h0);
        bus_write(3'd6, 32'h2);
        check_eq("last0_irq_clear", 32'(irq), 32'h0);

`ifdef CINERARIA_LED_PWM_EN
        begin
            int high_cnt;
            bus_read(3'd7, rd);
            check_eq("bright_reset", rd, 32'hFF);
            bus_write(3'd0, 32'h3FF);
            bus_write(3'd7, 32'h40);
            bus_read(3'd7, rd);
            check_eq("bright_readback", rd, 32'h40);
            repeat (2) @(negedge clk);
            high_cnt = 0;
            for (int i = 0; i < 256; i++) begin
                @(negedge clk);
                if (out_port == 10'h3FF) high_cnt++;
            end
            check_eq("pwm_duty", 32'(high_cnt), 32'd64);
        end
`else
        bus_write(3'd7, 32'h55);
        bus_read(3'd7, rd);
        check_eq("addr7_reads_zero", rd, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
